// File: rtl/uart_core.sv
// Full-duplex UART: programmable baud generator, Tx and Rx frame engines on one CPU clock.
// Frame: start, 7/8 data bits LSB first, optional odd/even parity, one stop bit.
module uart_core #(
   parameter int BASE_DIV    = 400,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_CPU,
   input  logic       RST,
   input  logic       EN,
   input  logic [3:0] bitrate,
   input  logic       UART_WRITE,
   input  logic       UART_BITS,
   input  logic [1:0] UART_PARITY,
   input  logic [7:0] DATA_IN_Tx,
   input  logic       DATA_IN_Rx,
   output logic       DATA_OUT_Tx,
   output logic [9:0] DATA_OUT_Rx,
   output logic       UART_AVAIL,
   output logic       IRQ_Tx,
   output logic       IRQ_Rx,
   output logic       uart_clock
);
   localparam int CW = $clog2(BASE_DIV + 1);

   typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

   // ---------------- baud generator ----------------
   logic [2:0]    rate_sel;
   logic [CW-1:0] p_sel, p_cur, p_q, p_d, baud_cnt_q, baud_cnt_d;
   logic          baud_wrap, uart_clock_q, uart_clock_d;

   // The period is re-read from bitrate on the first count of every period, so a
   // change lands on the next wrap.
   always_comb begin
      // NOTE: every next-state value gets its hold value first, so no path can infer a latch.
      rate_sel     = bitrate[3] ? 3'd7 : bitrate[2:0];
      p_sel        = CW'(BASE_DIV >> rate_sel);
      p_cur        = (baud_cnt_q == '0) ? p_sel : p_q;
      baud_wrap    = EN && (baud_cnt_q == p_cur - CW'(1));
      p_d          = p_q;
      baud_cnt_d   = baud_cnt_q;
      if (EN) begin
         if (baud_cnt_q == '0) p_d = p_sel;
         baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + CW'(1);
      end
      uart_clock_d = (baud_cnt_d == '0) || (baud_cnt_d < (p_d >> 1));
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk_CPU or posedge RST) begin
      if (RST) begin
         p_q          <= CW'(BASE_DIV);
         baud_cnt_q   <= '0;
         uart_clock_q <= 1'b0;
      end else begin
         p_q          <= p_d;
         baud_cnt_q   <= baud_cnt_d;
         uart_clock_q <= uart_clock_d;
      end
   end

   // ---------------- transmitter ----------------
   tx_state_e  tx_state_q, tx_state_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       tx_bits_q, tx_bits_d;
   logic [1:0] tx_par_q, tx_par_d;
   logic [2:0] tx_idx_q, tx_idx_d;
   logic       tx_line_q, tx_line_d, irq_tx_q, irq_tx_d;
   logic       tx_par_en, tx_par_bit;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_data_d  = tx_data_q;
      tx_bits_d  = tx_bits_q;
      tx_par_d   = tx_par_q;
      tx_idx_d   = tx_idx_q;
      tx_line_d  = tx_line_q;
      irq_tx_d   = 1'b0;
      tx_par_en  = (tx_par_q == 2'b01) || (tx_par_q == 2'b10);
      tx_par_bit = (^tx_data_q) ^ (tx_par_q == 2'b01);
      case (tx_state_q)
         TX_IDLE: if (EN && UART_WRITE) begin
            tx_data_d  = UART_BITS ? DATA_IN_Tx : {1'b0, DATA_IN_Tx[6:0]};
            tx_bits_d  = UART_BITS;
            tx_par_d   = UART_PARITY;
            tx_state_d = TX_WAIT;
         end
         TX_WAIT: if (baud_wrap) begin
            tx_state_d = TX_START;
            tx_line_d  = 1'b0;
         end
         TX_START: if (baud_wrap) begin
            tx_state_d = TX_DATA;
            tx_idx_d   = 3'd0;
            tx_line_d  = tx_data_q[0];
         end
         TX_DATA: if (baud_wrap) begin
            if (tx_idx_q == {2'b11, tx_bits_q}) begin
               tx_state_d = tx_par_en ? TX_PARITY : TX_STOP;
               tx_line_d  = tx_par_en ? tx_par_bit : 1'b1;
            end else begin
               tx_idx_d  = tx_idx_q + 3'd1;
               tx_line_d = tx_data_q[tx_idx_d];
            end
         end
         TX_PARITY: if (baud_wrap) begin
            tx_state_d = TX_STOP;
            tx_line_d  = 1'b1;
         end
         TX_STOP: if (baud_wrap) begin
            tx_state_d = TX_IDLE;
            irq_tx_d   = 1'b1;
         end
         default: begin
            tx_state_d = TX_IDLE;
            tx_line_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_CPU or posedge RST) begin
      if (RST) begin
         tx_state_q <= TX_IDLE;
         tx_data_q  <= '0;
         tx_bits_q  <= 1'b0;
         tx_par_q   <= '0;
         tx_idx_q   <= '0;
         tx_line_q  <= 1'b1;
         irq_tx_q   <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_data_q  <= tx_data_d;
         tx_bits_q  <= tx_bits_d;
         tx_par_q   <= tx_par_d;
         tx_idx_q   <= tx_idx_d;
         tx_line_q  <= tx_line_d;
         irq_tx_q   <= irq_tx_d;
      end
   end

   // ---------------- receiver ----------------
   logic [SYNC_STAGES-1:0] rx_sync_q;
   logic                   rx_s, rx_prev_q;
   rx_state_e  rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d, rx_p_q, rx_p_d;
   logic       rx_bits_q, rx_bits_d;
   logic [1:0] rx_par_q, rx_par_d;
   logic [2:0] rx_idx_q, rx_idx_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_pbit_q, rx_pbit_d;
   logic [9:0] rx_out_q, rx_out_d;
   logic       irq_rx_q, irq_rx_d;
   logic       rx_par_en, rx_par_err, rx_sample;

   assign rx_s = rx_sync_q[SYNC_STAGES-1];

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_p_d     = rx_p_q;
      rx_bits_d  = rx_bits_q;
      rx_par_d   = rx_par_q;
      rx_idx_d   = rx_idx_q;
      rx_data_d  = rx_data_q;
      rx_pbit_d  = rx_pbit_q;
      rx_out_d   = rx_out_q;
      irq_rx_d   = 1'b0;
      rx_par_en  = (rx_par_q == 2'b01) || (rx_par_q == 2'b10);
      rx_par_err = rx_par_en && ((^{rx_data_q, rx_pbit_q}) != (rx_par_q == 2'b01));
      rx_sample  = (rx_cnt_q == rx_p_q - CW'(1));
      if (EN) begin
         rx_cnt_d = rx_cnt_q + CW'(1);
         case (rx_state_q)
            RX_IDLE: begin
               rx_cnt_d = '0;
               if (rx_prev_q && !rx_s) begin
                  rx_state_d = RX_START;
                  rx_p_d     = p_sel;
                  rx_bits_d  = UART_BITS;
                  rx_par_d   = UART_PARITY;
                  rx_data_d  = '0;
               end
            end
            // Half a bit after the falling edge the line must still be low.
            RX_START: if (rx_cnt_q == (rx_p_q >> 1) - CW'(1)) begin
               rx_cnt_d   = '0;
               rx_idx_d   = 3'd0;
               rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_sample) begin
               rx_cnt_d            = '0;
               rx_data_d[rx_idx_q] = rx_s;
               if (rx_idx_q == {2'b11, rx_bits_q}) rx_state_d = rx_par_en ? RX_PARITY : RX_STOP;
               else                                rx_idx_d   = rx_idx_q + 3'd1;
            end
            RX_PARITY: if (rx_sample) begin
               rx_cnt_d   = '0;
               rx_pbit_d  = rx_s;
               rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_sample) begin
               rx_cnt_d   = '0;
               rx_out_d   = {~rx_s, rx_par_err, rx_data_q};
               irq_rx_d   = 1'b1;
               rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_CPU or posedge RST) begin
      if (RST) begin
         rx_sync_q  <= '1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_p_q     <= CW'(BASE_DIV);
         rx_bits_q  <= 1'b0;
         rx_par_q   <= '0;
         rx_idx_q   <= '0;
         rx_data_q  <= '0;
         rx_pbit_q  <= 1'b0;
         rx_out_q   <= '0;
         irq_rx_q   <= 1'b0;
      end else begin
         rx_sync_q  <= (rx_sync_q << 1) | SYNC_STAGES'(DATA_IN_Rx);
         if (EN) rx_prev_q <= rx_s;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_p_q     <= rx_p_d;
         rx_bits_q  <= rx_bits_d;
         rx_par_q   <= rx_par_d;
         rx_idx_q   <= rx_idx_d;
         rx_data_q  <= rx_data_d;
         rx_pbit_q  <= rx_pbit_d;
         rx_out_q   <= rx_out_d;
         irq_rx_q   <= irq_rx_d;
      end
   end

   assign DATA_OUT_Tx = tx_line_q;
   assign UART_AVAIL  = (tx_state_q == TX_IDLE);
   assign IRQ_Tx      = irq_tx_q;
   assign IRQ_Rx      = irq_rx_q;
   assign DATA_OUT_Rx = rx_out_q;
   assign uart_clock  = uart_clock_q;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: table-driven Tx and Rx frames plus hand-written
// sequences for reset, false start, enable freeze, busy write and loopback.
module tb_uart_core;
   timeunit 1ns;
   timeprecision 1ps;

   logic       clk_CPU = 1'b0;
   logic       RST, EN, UART_WRITE, UART_BITS;
   logic [3:0] bitrate;
   logic [1:0] UART_PARITY;
   logic [7:0] DATA_IN_Tx;
   logic       DATA_IN_Rx, DATA_OUT_Tx, UART_AVAIL, IRQ_Tx, IRQ_Rx, uart_clock;
   logic [9:0] DATA_OUT_Rx;
   logic       rx_drv, loop_en;

   int total = 0;
   int bad   = 0;
   int tx_irq_cnt = 0;
   int rx_irq_cnt = 0;
   logic [9:0] rx_cap = '0;

   assign DATA_IN_Rx = loop_en ? DATA_OUT_Tx : rx_drv;

   uart_core #(.BASE_DIV(400), .SYNC_STAGES(2)) dut (
      .clk_CPU(clk_CPU), .RST(RST), .EN(EN), .bitrate(bitrate),
      .UART_WRITE(UART_WRITE), .UART_BITS(UART_BITS), .UART_PARITY(UART_PARITY),
      .DATA_IN_Tx(DATA_IN_Tx), .DATA_IN_Rx(DATA_IN_Rx), .DATA_OUT_Tx(DATA_OUT_Tx),
      .DATA_OUT_Rx(DATA_OUT_Rx), .UART_AVAIL(UART_AVAIL), .IRQ_Tx(IRQ_Tx),
      .IRQ_Rx(IRQ_Rx), .uart_clock(uart_clock)
   );

   always #100 clk_CPU = ~clk_CPU;

   always @(negedge clk_CPU) begin
      if (IRQ_Tx === 1'b1) tx_irq_cnt = tx_irq_cnt + 1;
      if (IRQ_Rx === 1'b1) begin
         rx_irq_cnt = rx_irq_cnt + 1;
         rx_cap     = DATA_OUT_Rx;
      end
   end

   typedef struct {
      logic        bits;
      logic [1:0]  par;
      logic [3:0]  rate;
      int          p;
      logic [7:0]  data;
      int          len;
      logic [10:0] frame;   // line level per bit time, start bit in [0]
      bit          poke;    // fire a busy write with altered inputs mid-frame
   } tx_vec_t;

   typedef struct {
      logic        bits;
      logic [1:0]  par;
      logic [3:0]  rate;
      int          p;
      int          len;
      logic [10:0] frame;
      logic [9:0]  exp;
   } rx_vec_t;

   tx_vec_t tx_vecs[6];
   rx_vec_t rx_vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_tx(input tx_vec_t v, input int idx);
      int   wait_c, irq0;
      logic ok_line, ok_busy, ok_clk, ok_idle;
      bitrate = v.rate; UART_BITS = v.bits; UART_PARITY = v.par; DATA_IN_Tx = v.data;
      @(negedge clk_CPU);
      check($sformatf("tx%0d avail idle", idx), 32'(UART_AVAIL), 1);
      irq0 = tx_irq_cnt;
      UART_WRITE = 1'b1;
      @(negedge clk_CPU);
      UART_WRITE = 1'b0;
      check($sformatf("tx%0d avail low after write", idx), 32'(UART_AVAIL), 0);
      wait_c = 0;
      while (DATA_OUT_Tx !== 1'b0 && wait_c < 1000) begin
         @(negedge clk_CPU);
         wait_c++;
      end
      check($sformatf("tx%0d start bit seen", idx), 32'(DATA_OUT_Tx), 0);
      ok_busy = 1'b1;
      ok_clk  = 1'b1;
      for (int b = 0; b < v.len; b++) begin
         ok_line = 1'b1;
         for (int k = 0; k < v.p; k++) begin
            if (DATA_OUT_Tx !== v.frame[b]) ok_line = 1'b0;
            if (UART_AVAIL !== 1'b0 || IRQ_Tx !== 1'b0) ok_busy = 1'b0;
            if (b == 0 && uart_clock !== (k < v.p / 2)) ok_clk = 1'b0;
            if (v.poke && b == 3 && k == 1) begin
               UART_WRITE = 1'b1; DATA_IN_Tx = ~v.data; UART_BITS = ~v.bits; UART_PARITY = ~v.par;
            end else begin
               UART_WRITE = 1'b0;
            end
            @(negedge clk_CPU);
         end
         check($sformatf("tx%0d bit%0d level", idx, b), 32'(ok_line), 1);
      end
      check($sformatf("tx%0d busy during frame", idx), 32'(ok_busy), 1);
      check($sformatf("tx%0d uart_clock duty", idx), 32'(ok_clk), 1);
      check($sformatf("tx%0d irq at stop end", idx), 32'(IRQ_Tx), 1);
      check($sformatf("tx%0d avail at stop end", idx), 32'(UART_AVAIL), 1);
      ok_idle = 1'b1;
      for (int k = 0; k < 2 * v.p; k++) begin
         @(negedge clk_CPU);
         if (DATA_OUT_Tx !== 1'b1 || UART_AVAIL !== 1'b1 || IRQ_Tx !== 1'b0) ok_idle = 1'b0;
      end
      check($sformatf("tx%0d idle after frame", idx), 32'(ok_idle), 1);
      check($sformatf("tx%0d irq count", idx), 32'(tx_irq_cnt), 32'(irq0 + 1));
   endtask

   task automatic run_rx(input rx_vec_t v, input int idx);
      int irq0;
      bitrate = v.rate; UART_BITS = v.bits; UART_PARITY = v.par;
      irq0 = rx_irq_cnt;
      repeat (4) @(negedge clk_CPU);
      for (int b = 0; b < v.len; b++) begin
         rx_drv = v.frame[b];
         repeat (v.p) @(negedge clk_CPU);
      end
      rx_drv = 1'b1;
      repeat (2 * v.p + 4) @(negedge clk_CPU);
      check($sformatf("rx%0d irq count", idx), 32'(rx_irq_cnt), 32'(irq0 + 1));
      check($sformatf("rx%0d data at irq", idx), 32'(rx_cap), 32'(v.exp));
      check($sformatf("rx%0d data held", idx), 32'(DATA_OUT_Rx), 32'(v.exp));
   endtask

   initial begin
      int   wait_c, irq0;
      logic ok;
      tx_vecs[0] = '{1'b1, 2'b01, 4'd2,  100, 8'h5A, 11, 11'b11010110100, 1'b0};
      tx_vecs[1] = '{1'b0, 2'b00, 4'd7,    3, 8'h41,  9, 11'b00110000010, 1'b0};
      tx_vecs[2] = '{1'b1, 2'b10, 4'd5,   12, 8'h3C, 11, 11'b10001111000, 1'b1};
      tx_vecs[3] = '{1'b0, 2'b01, 4'd6,    6, 8'hFF, 10, 11'b01011111110, 1'b0};
      tx_vecs[4] = '{1'b1, 2'b11, 4'd3,   50, 8'h80, 10, 11'b01100000000, 1'b1};
      tx_vecs[5] = '{1'b1, 2'b10, 4'd12,   3, 8'h01, 11, 11'b11000000010, 1'b0};

      rx_vecs[0] = '{1'b1, 2'b10, 4'd2, 100, 11, 11'b10001111000, 10'h03C};
      rx_vecs[1] = '{1'b0, 2'b01, 4'd2, 100, 10, 11'b00010000010, 10'h341};
      rx_vecs[2] = '{1'b1, 2'b01, 4'd5,  12, 11, 11'b11101001010, 10'h0A5};
      rx_vecs[3] = '{1'b1, 2'b00, 4'd4,  25, 10, 11'b01111111110, 10'h0FF};
      rx_vecs[4] = '{1'b0, 2'b10, 4'd3,  50, 10, 11'b01110101010, 10'h155};
      rx_vecs[5] = '{1'b0, 2'b11, 4'd6,   6,  9, 11'b00001010100, 10'h22A};

      RST = 1'b1; EN = 1'b1; bitrate = 4'd2; UART_WRITE = 1'b0; UART_BITS = 1'b1;
      UART_PARITY = 2'b00; DATA_IN_Tx = 8'h00; rx_drv = 1'b1; loop_en = 1'b0;
      repeat (3) @(negedge clk_CPU);
      check("reset tx line", 32'(DATA_OUT_Tx), 1);
      check("reset avail", 32'(UART_AVAIL), 1);
      check("reset irq_tx", 32'(IRQ_Tx), 0);
      check("reset irq_rx", 32'(IRQ_Rx), 0);
      check("reset rx data", 32'(DATA_OUT_Rx), 0);
      check("reset uart_clock", 32'(uart_clock), 0);
      RST = 1'b0;

      for (int i = 0; i < 6; i++) run_tx(tx_vecs[i], i);
      for (int i = 0; i < 6; i++) run_rx(rx_vecs[i], i);

      // False start: short low glitch must not produce a frame.
      bitrate = 4'd2;
      irq0 = rx_irq_cnt;
      rx_drv = 1'b0;
      repeat (30) @(negedge clk_CPU);
      rx_drv = 1'b1;
      repeat (300) @(negedge clk_CPU);
      check("false start irq", 32'(rx_irq_cnt), 32'(irq0));
      check("false start data held", 32'(DATA_OUT_Rx), 32'(rx_vecs[5].exp));

      // EN low for 500 cycles inside data bit 3 of 0x0F stretches that bit by 500.
      bitrate = 4'd2; UART_BITS = 1'b1; UART_PARITY = 2'b00; DATA_IN_Tx = 8'h0F;
      @(negedge clk_CPU);
      UART_WRITE = 1'b1;
      @(negedge clk_CPU);
      UART_WRITE = 1'b0;
      wait_c = 0;
      while (DATA_OUT_Tx !== 1'b0 && wait_c < 1000) begin
         @(negedge clk_CPU);
         wait_c++;
      end
      check("en start bit seen", 32'(DATA_OUT_Tx), 0);
      ok = 1'b1;
      for (int c = 0; c <= 1500; c++) begin
         if (c > 450 && c < 950 && (IRQ_Tx !== 1'b0 || DATA_OUT_Tx !== 1'b1)) ok = 1'b0;
         if (c == 999)  check("en stretched bit end", 32'(DATA_OUT_Tx), 1);
         if (c == 1000) check("en next bit", 32'(DATA_OUT_Tx), 0);
         if (c == 1000) check("en no early irq", 32'(IRQ_Tx), 0);
         if (c == 1499) check("en irq not yet", 32'(IRQ_Tx), 0);
         if (c == 1500) check("en irq delayed", 32'(IRQ_Tx), 1);
         if (c == 450) EN = 1'b0;
         if (c == 950) EN = 1'b1;
         if (c < 1500) @(negedge clk_CPU);
      end
      check("en hold while low", 32'(ok), 1);

      // Loopback at the fastest rate.
      loop_en = 1'b1;
      bitrate = 4'd7; UART_BITS = 1'b1; UART_PARITY = 2'b01; DATA_IN_Tx = 8'hA5;
      repeat (5) @(negedge clk_CPU);
      irq0 = rx_irq_cnt;
      UART_WRITE = 1'b1;
      @(negedge clk_CPU);
      UART_WRITE = 1'b0;
      repeat (100) @(negedge clk_CPU);
      check("loopback irq", 32'(rx_irq_cnt), 32'(irq0 + 1));
      check("loopback data", 32'(DATA_OUT_Rx), 32'h0A5);
      loop_en = 1'b0;

      // Asynchronous reset in the middle of a frame.
      bitrate = 4'd2; UART_BITS = 1'b1; UART_PARITY = 2'b01; DATA_IN_Tx = 8'h5A;
      @(negedge clk_CPU);
      UART_WRITE = 1'b1;
      @(negedge clk_CPU);
      UART_WRITE = 1'b0;
      wait_c = 0;
      while (DATA_OUT_Tx !== 1'b0 && wait_c < 1000) begin
         @(negedge clk_CPU);
         wait_c++;
      end
      repeat (150) @(negedge clk_CPU);
      check("pre-reset line low", 32'(DATA_OUT_Tx), 0);
      #30 RST = 1'b1;
      #1;
      check("async reset tx line", 32'(DATA_OUT_Tx), 1);
      check("async reset avail", 32'(UART_AVAIL), 1);
      check("async reset irq_tx", 32'(IRQ_Tx), 0);
      check("async reset irq_rx", 32'(IRQ_Rx), 0);
      check("async reset rx data", 32'(DATA_OUT_Rx), 0);
      @(negedge clk_CPU);
      RST = 1'b0;
      irq0 = tx_irq_cnt;
      ok = 1'b1;
      for (int c = 0; c < 1200; c++) begin
         @(negedge clk_CPU);
         if (DATA_OUT_Tx !== 1'b1 || UART_AVAIL !== 1'b1) ok = 1'b0;
      end
      check("aborted frame stays idle", 32'(ok), 1);
      check("aborted frame no irq", 32'(tx_irq_cnt), 32'(irq0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
